// File: rtl/cpld_pkg.sv
// rtl/cpld_pkg.sv - shared CPLD sequencer types, constants and output decode
package cpld_pkg;

  // CPU sequencer state encoding; also exported on the state port for LEDs/debug
  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_DELAY   = 3'd1,
    ST_PULSE   = 3'd2,
    ST_WAIT_RS = 3'd3,
    ST_RETRY   = 3'd4,
    ST_HUB     = 3'd5,
    ST_RUN     = 3'd6,
    ST_FAULT   = 3'd7
  } cpu_seq_state_t;

  // c66x_sequencer state that the top level decodes into dsp_ready
  localparam logic [3:0] C66X_READY = 4'b1001;

  // Default timing at roughly 4 MHz sysclk
  localparam int unsigned CPU_SEQ_CNT_W       = 24;
  localparam int unsigned CPU_SEQ_DELAY       = 12582912;
  localparam int unsigned CPU_SEQ_PULSE       = 4194304;
  localparam int unsigned CPU_SEQ_TIMEOUT     = 16777215;
  localparam int unsigned CPU_SEQ_HUB         = 4096;
  localparam int unsigned CPU_SEQ_MAX_RETRIES = 3;

  // Pin-level view of one sequencer state
  typedef struct packed {
    logic pwron_drive;
    logic reset_hold;
    logic hub_release;
    logic running;
    logic fault;
  } cpu_seq_out_t;

  // Map a state to its pin levels; everything not listed keeps the CPU held and PWRON released
  function automatic cpu_seq_out_t cpu_seq_decode(input cpu_seq_state_t s);
    cpu_seq_out_t o;
    o.pwron_drive = 1'b0;
    o.reset_hold  = 1'b1;
    o.hub_release = 1'b0;
    o.running     = 1'b0;
    o.fault       = 1'b0;
    case (s)
      ST_PULSE: begin
        o.pwron_drive = 1'b1;
        o.reset_hold  = 1'b0;
      end
      ST_WAIT_RS: o.reset_hold = 1'b0;
      ST_HUB:     o.reset_hold = 1'b0;
      ST_RUN: begin
        o.reset_hold  = 1'b0;
        o.hub_release = 1'b1;
        o.running     = 1'b1;
      end
      ST_FAULT: o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchronizer for asynchronous CPLD pins
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - Exynos CPU power-on, RESETOUT wait, retry and USB hub sequencer
module cpu_sequencer
  import cpld_pkg::*;
#(
  parameter int unsigned CNT_W          = CPU_SEQ_CNT_W,
  parameter int unsigned DELAY_CYCLES   = CPU_SEQ_DELAY,
  parameter int unsigned PULSE_CYCLES   = CPU_SEQ_PULSE,
  parameter int unsigned TIMEOUT_CYCLES = CPU_SEQ_TIMEOUT,
  parameter int unsigned HUB_CYCLES     = CPU_SEQ_HUB,
  parameter int unsigned MAX_RETRIES    = CPU_SEQ_MAX_RETRIES
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       dsp_ready,
  input  logic       cpu_resetout,
  output logic       pmic_pwron_drive,
  output logic       cpu_reset_hold,
  output logic       usbhub_reset_INV,
  output logic       cpu_running,
  output logic       fault,
  output logic [2:0] state
);

  // Terminal counts: a timed state lasts exactly N cycles, so it ends at count N-1
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HUB_LAST     = CNT_W'(HUB_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  logic           rs_sync;
  cpu_seq_state_t state_q;
  cpu_seq_state_t state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]     retry_q;
  cpu_seq_out_t   out_q;

  logic delay_done;
  logic pulse_done;
  logic timeout_done;
  logic hub_done;

  sync2 #(
    .RESET_VAL(1'b0)
  ) u_rs_sync (
    .clk    (sysclk),
    .resetn (reset_INV),
    .d      (cpu_resetout),
    .q      (rs_sync)
  );

  assign delay_done   = (cnt_q == DELAY_LAST);
  assign pulse_done   = (cnt_q == PULSE_LAST);
  assign timeout_done = (cnt_q == TIMEOUT_LAST);
  assign hub_done     = (cnt_q == HUB_LAST);

  // Next-state selection; losing dsp_ready overrides everything, RESETOUT beats a coincident timeout
  always_comb begin
    state_nxt = state_q;
    if (!dsp_ready) begin
      state_nxt = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:     state_nxt = ST_DELAY;
        ST_DELAY:   if (delay_done) state_nxt = ST_PULSE;
        ST_PULSE:   if (pulse_done) state_nxt = ST_WAIT_RS;
        ST_WAIT_RS: begin
          if (rs_sync)           state_nxt = ST_HUB;
          else if (timeout_done) state_nxt = ST_RETRY;
        end
        ST_RETRY: begin
          if (delay_done) state_nxt = (retry_q == RETRY_LIMIT) ? ST_FAULT : ST_PULSE;
        end
        ST_HUB:     if (hub_done) state_nxt = ST_RUN;
        ST_RUN:     if (!rs_sync) state_nxt = ST_WAIT_RS;
        ST_FAULT:   state_nxt = ST_FAULT;
        default:    state_nxt = ST_OFF;
      endcase
    end
  end

  // State, shared counter, retry count and pin levels decoded from the next state
  always_ff @(posedge sysclk) begin
    if (!reset_INV) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= cpu_seq_decode(ST_OFF);
    end else begin
      state_q <= state_nxt;
      out_q   <= cpu_seq_decode(state_nxt);
      if ((state_nxt != state_q) || (state_nxt == ST_OFF)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (!dsp_ready) begin
        retry_q <= '0;
      end else if ((state_q == ST_WAIT_RS) && (state_nxt == ST_RETRY)) begin
        retry_q <= retry_q + 2'd1;
      end
    end
  end

  assign pmic_pwron_drive = out_q.pwron_drive;
  assign cpu_reset_hold   = out_q.reset_hold;
  assign usbhub_reset_INV = out_q.hub_release;
  assign cpu_running      = out_q.running;
  assign fault            = out_q.fault;
  assign state            = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic       sysclk = 1'b0;
  logic       reset_INV;
  logic       dsp_ready;
  logic       cpu_resetout;
  logic       pmic_pwron_drive;
  logic       cpu_reset_hold;
  logic       usbhub_reset_INV;
  logic       cpu_running;
  logic       fault;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         scn;
    int         cyc;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 sysclk = ~sysclk;

  cpu_sequencer #(
    .CNT_W          (8),
    .DELAY_CYCLES   (10),
    .PULSE_CYCLES   (5),
    .TIMEOUT_CYCLES (20),
    .HUB_CYCLES     (4),
    .MAX_RETRIES    (3)
  ) dut (
    .sysclk           (sysclk),
    .reset_INV        (reset_INV),
    .dsp_ready        (dsp_ready),
    .cpu_resetout     (cpu_resetout),
    .pmic_pwron_drive (pmic_pwron_drive),
    .cpu_reset_hold   (cpu_reset_hold),
    .usbhub_reset_INV (usbhub_reset_INV),
    .cpu_running      (cpu_running),
    .fault            (fault),
    .state            (state)
  );

  function automatic vec_t mk(input int s, input int c, input int st,
                              input bit pw, input bit hold, input bit hub,
                              input bit run, input bit flt);
    vec_t v;
    v.scn = s;
    v.cyc = c;
    v.exp = {3'(st), pw, hold, hub, run, flt};
    return v;
  endfunction

  function automatic logic [7:0] obs();
    return {state, pmic_pwron_drive, cpu_reset_hold, usbhub_reset_INV, cpu_running, fault};
  endfunction

  function automatic logic dsp_at(input int s, input int c);
    if (s == 3) return logic'(!(c >= 12 && c < 16));
    return 1'b1;
  endfunction

  function automatic logic pin_at(input int s, input int c);
    if (s == 0) return logic'(c >= 18 && c != 30);
    if (s == 2) return logic'(c >= 33 && c < 45);
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got st=%0d pw/hold/hub/run/flt=%b, want st=%0d %b",
               name, act[7:5], act[4:0], exp[7:5], exp[4:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input int s);
    @(negedge sysclk);
    reset_INV    = 1'b0;
    dsp_ready    = 1'b0;
    cpu_resetout = 1'b0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check($sformatf("scn%0d_reset", s), obs(), {3'd0, 5'b01000});
    reset_INV = 1'b1;
  endtask

  task automatic run_scn(input int s, input int ncyc, input int exp_pulses);
    vec_t exp_q[$];
    vec_t v;
    int   pulses = 0;
    do_reset(s);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].scn == s) exp_q.push_back(tbl[i]);
    end
    for (int c = 0; c < ncyc; c++) begin
      dsp_ready    = dsp_at(s, c);
      cpu_resetout = pin_at(s, c);
      @(posedge sysclk);
      @(negedge sysclk);
      if (pmic_pwron_drive) pulses++;
      while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
        v = exp_q.pop_front();
        check($sformatf("scn%0d_cyc%0d", s, c), obs(), v.exp);
      end
    end
    check_int($sformatf("scn%0d_unchecked", s), exp_q.size(), 0);
    check_int($sformatf("scn%0d_pwron_cycles", s), pulses, exp_pulses);
  endtask

  initial begin
    reset_INV    = 1'b0;
    dsp_ready    = 1'b0;
    cpu_resetout = 1'b0;

    // scn0: normal bring-up, then a one-cycle warm reset from RUN
    tbl.push_back(mk(0,  0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0,  9, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 10, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 14, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 15, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 19, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 20, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 23, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 24, 6, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 31, 6, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 32, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 33, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 36, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 37, 6, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 39, 6, 0, 0, 1, 1, 0));
    // scn1: RESETOUT never comes, three pulses then FAULT
    tbl.push_back(mk(1,  10, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  14, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  15, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  34, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  35, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1,  44, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1,  45, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  49, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  50, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  70, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1,  80, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  84, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  85, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 105, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 114, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 115, 7, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 130, 7, 0, 1, 0, 0, 1));
    // scn2: RESETOUT lands on the last timeout cycle; later loss proves zero retries were used
    tbl.push_back(mk(2,  34, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2,  35, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2,  38, 5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2,  39, 6, 0, 0, 1, 1, 0));
    tbl.push_back(mk(2,  46, 6, 0, 0, 1, 1, 0));
    tbl.push_back(mk(2,  47, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2,  67, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2,  77, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(2, 102, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, 112, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(2, 137, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, 146, 4, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, 147, 7, 0, 1, 0, 0, 1));
    tbl.push_back(mk(2, 149, 7, 0, 1, 0, 0, 1));
    // scn3: dsp_ready drops on the second pulse cycle, then returns
    tbl.push_back(mk(3, 11, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3, 12, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3, 13, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3, 15, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3, 16, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3, 25, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3, 26, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3, 30, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3, 31, 3, 0, 0, 0, 0, 0));

    run_scn(0, 40, 5);

    run_scn(1, 131, 15);
    // Synchronous reset taken in FAULT: nothing moves until the next rising edge
    reset_INV = 1'b0;
    #1;
    check("fault_reset_before_edge", obs(), {3'd7, 5'b01001});
    @(posedge sysclk);
    @(negedge sysclk);
    check("fault_reset_after_edge", obs(), {3'd0, 5'b01000});

    run_scn(2, 150, 15);
    run_scn(3, 32, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Power-on and reset sequencer for the Exynos CPU module.
- Sits directly downstream of c66x_sequencer. Starts only after the top level decodes the DSP sequencer's ready state (4'b1001) into dsp_ready.
- Drives the PMIC PWRON pulse and waits for the CPU RESETOUT, with a timeout and bounded retries.
- Then sequences the USB hub reset and reports its status. It replaces the free-running power-on timer in cpld_top.

Parameters:
- CNT_W, 24, width of the shared delay/timeout counter.
- DELAY_CYCLES, 12582912, sysclk cycles from dsp_ready to the start of the PWRON pulse (about 3 s at 4 MHz).
- PULSE_CYCLES, 4194304, length of the PWRON drive-high pulse.
- TIMEOUT_CYCLES, 16777215, maximum wait for cpu_resetout after the pulse ends.
- HUB_CYCLES, 4096, length of the USB hub reset after cpu_resetout is seen.
- MAX_RETRIES, 3, number of PWRON retries before latching a fault (2-bit counter).

Ports:
- sysclk  input  1  Sequencer clock (UFM oscillator, 3.3-5.5 MHz).
- reset_INV  input  1  Active-low reset.
- dsp_ready  input  1  DSP sequencer has reached its ready state. Synchronous to sysclk.
- cpu_resetout  input  1  CPU RESETOUT pin; high means the CPU is out of reset. Asynchronous.
- pmic_pwron_drive  output  1  1 = top level drives PWRON high; 0 = top level releases PWRON (Z).
- cpu_reset_hold  output  1  1 = top level drives cpu_reset_INV low; 0 = released.
- usbhub_reset_INV  output  1  USB hub reset, active-low, push-pull.
- cpu_running  output  1  Sequence complete and CPU alive.
- fault  output  1  Retries exhausted; sticky until reset or dsp_ready falls.
- state  output  3  Current FSM state encoding, used for LED/debug.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is sysclk and reset port is reset_INV.
- All registers are updated on the rising edge of sysclk. Reset is sampled only at that edge.
- Reset values of outputs:
  - pmic_pwron_drive = 0
  - cpu_reset_hold = 1
  - usbhub_reset_INV = 0
  - cpu_running = 0
  - fault = 0
  - state = OFF
  - counter = 0
  - retry count = 0
- cpu_resetout passes through a 2-flop synchronizer (rs_sync). All FSM decisions use the synchronized value, which lags the pin by 2 cycles.
- The counter is CNT_W bits. It clears on every state transition and otherwise increments. A duration expires when counter == X-1, so each timed state lasts exactly X cycles.
- OFF (0):
  - Outputs: pwron_drive 0, reset_hold 1, hub_INV 0.
  - Go to DELAY when dsp_ready = 1.
- DELAY (1): wait DELAY_CYCLES, then go to PULSE.
- PULSE (2):
  - pwron_drive = 1 for PULSE_CYCLES.
  - reset_hold falls to 0 on entry to PULSE.
  - Then go to WAIT_RS.
- WAIT_RS (3):
  - If rs_sync = 1, go to HUB.
  - If TIMEOUT_CYCLES expire first, go to RETRY.
  - If rs_sync rises on the same cycle as the timeout expires, go to HUB (success wins).
- RETRY (4):
  - reset_hold = 1. Wait DELAY_CYCLES with pwron released.
  - Increment the retry count.
  - If the count now equals MAX_RETRIES, go to FAULT; otherwise go to PULSE.
- HUB (5): hub_INV = 0 for HUB_CYCLES, then go to RUN.
- RUN (6):
  - hub_INV = 1 and cpu_running = 1.
  - If rs_sync falls (CPU watchdog or warm reset): cpu_running drops the next cycle and the FSM goes to WAIT_RS. The retry count is unchanged; the timeout restarts.
- FAULT (7):
  - fault = 1, reset_hold = 1, pwron_drive = 0, hub_INV = 0.
  - Stays here until reset or dsp_ready = 0.
- dsp_ready = 0 in any state: go to OFF on the next edge. This overrides every other transition and clears the counter, retry count and fault. A PWRON pulse in progress is truncated.
- All outputs are registered and decoded from the state; no combinational path from any input to any output.
- state equals the encodings listed above.

Decomposition:
- cpld_pkg holds:
  - the cpu_seq_state_t encoding (OFF..FAULT, 3 bits);
  - C66X_READY = 4'b1001, used by the top level to derive dsp_ready;
  - the default cycle constants.
- One sub-module, sync2: a generic 2-flop synchronizer with a reset value parameter (0 here). It is reused for other async pins in the CPLD.

Test Plan (bench overrides DELAY=10, PULSE=5, TIMEOUT=20, HUB=4, MAX_RETRIES=3):
- Normal bring-up:
  - Stimulus: reset_INV low for 2 cycles; dsp_ready high at cycle 0; cpu_resetout high 3 cycles after PULSE ends.
  - Required: pwron_drive high for exactly cycles 10-14. reset_hold falls at cycle 10. HUB entered 2 cycles after the pin rises. hub_INV rises 4 cycles later. cpu_running = 1.
- Timeout retry:
  - Stimulus: cpu_resetout held low.
  - Required: 3 PULSEs, each 5 cycles, separated by 20+10 cycles. fault = 1 after the third timeout, state = 7, and pwron_drive stays 0 thereafter.
- Race at timeout: cpu_resetout synchronized high on exactly the 20th WAIT_RS cycle -> HUB, not RETRY, and the retry count stays 0.
- Warm reset:
  - Stimulus: in RUN, pulse cpu_resetout low for 1 cycle and then keep it high.
  - Required: cpu_running drops, the FSM passes through WAIT_RS, and returns to RUN via a 4-cycle HUB. No PWRON pulse occurs.
- Abort mid-pulse: dsp_ready falls on the 2nd PULSE cycle -> next cycle state = OFF, pwron_drive = 0, reset_hold = 1. Re-asserting dsp_ready restarts the full DELAY.
- Sync reset: reset_INV asserted in FAULT -> all outputs take their reset values at the next edge, not before.
